// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave responder: default frame width and FSM state type.
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detection on the synced value.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] stage_q;
    logic                   prev_q;

    // Reset to the pin's idle level so leaving reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], din_i};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave (CPOL=1, MSB first): oversampled pins, frame FSM, RX shifter and 1-entry TX holding buffer.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_bar,
    input  logic                  din_mosi,
    output logic                  dout_miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_done,
    output logic                  frame_err
);

    localparam int unsigned    CntW    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    logic s_sclk, sclk_rise, sclk_fall;
    logic s_cs, cs_rise, cs_fall;
    logic s_mosi, mosi_rise_unused, mosi_fall_unused;

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .din_i  (sclk),
        .sync_o (s_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .din_i  (cs_bar),
        .sync_o (s_cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk    (clk),
        .reset  (reset),
        .din_i  (din_mosi),
        .sync_o (s_mosi),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    state_t                state_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic                  first_fall_q;
    logic [DATA_WIDTH-1:0] shift_tx_q;
    logic [DATA_WIDTH-1:0] shift_rx_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic                  buf_full_q;
    logic                  dout_q;
    logic                  oe_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_done_q;
    logic                  frame_err_q;

    logic                  last_rise;
    logic [DATA_WIDTH-1:0] rx_next;

    assign last_rise = sclk_rise && (bit_cnt_q == LastBit);
    assign rx_next   = {shift_rx_q[DATA_WIDTH-2:0], s_mosi};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            first_fall_q <= 1'b0;
            shift_tx_q   <= '0;
            shift_rx_q   <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            dout_q       <= 1'b0;
            oe_q         <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;

            // Only fills when empty; the frame-start consume below only fires when full.
            if (tx_valid && !buf_full_q) begin
                buf_q      <= tx_data;
                buf_full_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt_q    <= '0;
                        first_fall_q <= 1'b1;
                        oe_q         <= 1'b1;
                        state_q      <= SHIFT;
                        if (buf_full_q) begin
                            shift_tx_q <= buf_q;
                            dout_q     <= buf_q[DATA_WIDTH-1];
                            buf_full_q <= 1'b0;
                        end else begin
                            shift_tx_q <= '0;
                            dout_q     <= 1'b0;
                        end
                    end
                end

                SHIFT: begin
                    // The master samples the MSB on the first rise, so the first fall holds it.
                    if (sclk_fall) begin
                        if (first_fall_q) begin
                            first_fall_q <= 1'b0;
                        end else begin
                            shift_tx_q <= shift_tx_q << 1;
                            dout_q     <= shift_tx_q[DATA_WIDTH-2];
                        end
                    end
                    if (sclk_rise) begin
                        shift_rx_q <= rx_next;
                        bit_cnt_q  <= bit_cnt_q + CntW'(1);
                    end
                    if (last_rise) begin
                        rx_data_q  <= rx_next;
                        rx_valid_q <= 1'b1;
                        tx_done_q  <= 1'b1;
                        dout_q     <= 1'b0;
                        if (cs_rise) begin
                            oe_q    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        oe_q        <= 1'b0;
                        dout_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                DONE: begin
                    if (cs_rise) begin
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout_miso = dout_q;
    assign miso_oe   = oe_q;
    assign tx_ready  = ~buf_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_done   = tx_done_q;
    assign frame_err = frame_err_q;

endmodule
